// File: rtl/lfsr_way_picker.sv
// rtl/lfsr_way_picker.sv - XNOR-LFSR driven pseudo-random way picker with masked wrap-around selection.
// Optional lock-up recovery from the all-ones state: define LFSR_WAY_PICKER_LOCKUP_RECOVER_EN.
module lfsr_way_picker #(
   parameter int                    LFSR_WIDTH = 8,
   parameter int                    WAYS       = 8,
   parameter logic [LFSR_WIDTH-1:0] SEED       = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      en_i,
   input  logic                      load_i,
   input  logic [LFSR_WIDTH-1:0]     seed_i,
   input  logic [WAYS-1:0]           mask_i,
   output logic [WAYS-1:0]           way_oh_o,
   output logic [$clog2(WAYS)-1:0]   way_bin_o,
   output logic                      way_valid_o,
   output logic [LFSR_WIDTH-1:0]     state_o,
   output logic                      lockup_o
);

   localparam int IDXW = $clog2(WAYS);

   function automatic logic [31:0] tap_mask(input int width);
      case (width)
         4:       tap_mask = 32'h0000_000C;
         5:       tap_mask = 32'h0000_0014;
         6:       tap_mask = 32'h0000_0030;
         7:       tap_mask = 32'h0000_0060;
         8:       tap_mask = 32'h0000_00B8;
         12:      tap_mask = 32'h0000_0829;
         16:      tap_mask = 32'h0000_D008;
         24:      tap_mask = 32'h00E1_0000;
         32:      tap_mask = 32'h8020_0003;
         default: tap_mask = 32'h0000_0000;
      endcase
   endfunction

   localparam logic [31:0]           TAP32 = tap_mask(LFSR_WIDTH);
   localparam logic [LFSR_WIDTH-1:0] TAPS  = TAP32[LFSR_WIDTH-1:0];

   // Elaboration-time parameter checks; they stop simulation on illegal configurations.
   if (TAP32 == 32'h0) begin : g_bad_width
      $fatal(1, "lfsr_way_picker: illegal LFSR_WIDTH %0d", LFSR_WIDTH);
   end
   if ((WAYS < 2) || ((WAYS & (WAYS - 1)) != 0)) begin : g_bad_ways
      $fatal(1, "lfsr_way_picker: WAYS %0d is not a power of two >= 2", WAYS);
   end
   if ((LFSR_WIDTH < 31) && (WAYS > (1 << LFSR_WIDTH))) begin : g_ways_too_big
      $fatal(1, "lfsr_way_picker: WAYS %0d exceeds 2**LFSR_WIDTH", WAYS);
   end
   if (&SEED) begin : g_bad_seed
      $fatal(1, "lfsr_way_picker: SEED must not be all-ones");
   end

   logic [LFSR_WIDTH-1:0] state_q;
   logic [LFSR_WIDTH-1:0] state_d;
   logic                  feedback;
   logic                  lockup;

   assign feedback = ~^(state_q & TAPS);

`ifdef LFSR_WAY_PICKER_LOCKUP_RECOVER_EN
   assign lockup = &state_q;
`else
   assign lockup = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      if (lockup) begin
         state_d = SEED;
      end else if (load_i) begin
         state_d = seed_i;
      end else if (en_i) begin
         state_d = {state_q[LFSR_WIDTH-2:0], feedback};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   logic [IDXW-1:0] start_idx;
   logic [IDXW-1:0] cand_idx;

   assign start_idx = state_q[IDXW-1:0];

   // Scan offsets from the top down so the smallest offset from start_idx wins.
   always_comb begin
      way_oh_o    = '0;
      way_bin_o   = '0;
      way_valid_o = 1'b0;
      cand_idx    = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         cand_idx = start_idx + i[IDXW-1:0];
         if (mask_i[cand_idx]) begin
            way_oh_o    = {{(WAYS-1){1'b0}}, 1'b1} << cand_idx;
            way_bin_o   = cand_idx;
            way_valid_o = 1'b1;
         end
      end
   end

   assign state_o  = state_q;
   assign lockup_o = lockup;

endmodule

// File: tb/tb_lfsr_way_picker.sv
// tb/tb_lfsr_way_picker.sv - scoreboard bench for lfsr_way_picker (4-bit and 8-bit instances).
module tb_lfsr_way_picker;

   typedef struct {
      bit         sel8;
      string      name;
      logic [7:0] st;
      logic [7:0] oh;
      logic [2:0] bin;
      logic       valid;
      logic       lk;
   } exp_t;

   exp_t exp_q[$];
   event mon_ev;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst4, en4, load4;
   logic [3:0] seed4;
   logic [7:0] mask4, oh4;
   logic [2:0] bin4;
   logic       v4, lk4;
   logic [3:0] st4;

   logic       rst8, en8, load8;
   logic [7:0] seed8, mask8, oh8, st8;
   logic [2:0] bin8;
   logic       v8, lk8;

   lfsr_way_picker #(.LFSR_WIDTH(4), .WAYS(8), .SEED(4'h0)) u4 (
      .clk_i(clk), .rst_i(rst4), .en_i(en4), .load_i(load4), .seed_i(seed4),
      .mask_i(mask4), .way_oh_o(oh4), .way_bin_o(bin4), .way_valid_o(v4),
      .state_o(st4), .lockup_o(lk4));

   lfsr_way_picker #(.LFSR_WIDTH(8), .WAYS(8), .SEED(8'h00)) u8 (
      .clk_i(clk), .rst_i(rst8), .en_i(en8), .load_i(load8), .seed_i(seed8),
      .mask_i(mask8), .way_oh_o(oh8), .way_bin_o(bin8), .way_valid_o(v8),
      .state_o(st8), .lockup_o(lk8));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bit sel8, input string name, input logic [7:0] st,
                       input logic [7:0] oh, input logic [2:0] bin, input logic valid,
                       input logic lk);
      exp_t e;
      e.sel8 = sel8; e.name = name; e.st = st; e.oh = oh; e.bin = bin;
      e.valid = valid; e.lk = lk;
      exp_q.push_back(e);
   endtask

   // Expected outputs for a 4-bit state with every way eligible.
   task automatic push_full4(input string name, input logic [3:0] st, input logic lk);
      logic [2:0] b;
      b = st[2:0];
      push(1'b0, name, {4'h0, st}, 8'h01 << b, b, 1'b1, lk);
   endtask

   // Monitor: drains the scoreboard at each falling edge or on demand.
   initial begin
      exp_t       e;
      logic [7:0] a_st, a_oh;
      logic [2:0] a_bin;
      logic       a_v, a_lk;
      forever begin
         @(negedge clk or mon_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.sel8) begin
               a_st = st8; a_oh = oh8; a_bin = bin8; a_v = v8; a_lk = lk8;
            end else begin
               a_st = {4'h0, st4}; a_oh = oh4; a_bin = bin4; a_v = v4; a_lk = lk4;
            end
            n_checks++;
            if (a_st !== e.st || a_oh !== e.oh || a_bin !== e.bin ||
                a_v !== e.valid || a_lk !== e.lk) begin
               n_fail++;
               $display("FAIL %s: got state=%h oh=%h bin=%0d valid=%b lockup=%b, want state=%h oh=%h bin=%0d valid=%b lockup=%b",
                        e.name, a_st, a_oh, a_bin, a_v, a_lk,
                        e.st, e.oh, e.bin, e.valid, e.lk);
            end
         end
      end
   end

   logic [3:0] step_seq [16] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                                 4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};

   initial begin
      int  steps;
      bit  seen_ones;
      rst4 = 1'b1; en4 = 1'b0; load4 = 1'b0; seed4 = 4'h0; mask4 = 8'hFF;
      rst8 = 1'b1; en8 = 1'b0; load8 = 1'b0; seed8 = 8'h00; mask8 = 8'hFF;
      #2;
      push(1'b0, "reset4", 8'h00, 8'h01, 3'd0, 1'b1, 1'b0);
      push(1'b1, "reset8", 8'h00, 8'h01, 3'd0, 1'b1, 1'b0);

      tick();
      rst4 = 1'b0; rst8 = 1'b0;
      en4 = 1'b1;
      push_full4("step0", step_seq[0], 1'b0);
      for (int k = 1; k < 16; k++) begin
         tick();
         push_full4($sformatf("step%0d", k), step_seq[k], 1'b0);
      end
      en4 = 1'b0;

      load4 = 1'b1; en4 = 1'b1; seed4 = 4'hA;
      tick();
      push_full4("load_prio", 4'hA, 1'b0);
      load4 = 1'b0; en4 = 1'b0;
      tick();
      push_full4("hold", 4'hA, 1'b0);

      load4 = 1'b1; seed4 = 4'h5;
      tick();
      load4 = 1'b0;
      mask4 = 8'h03;
      push(1'b0, "mask_wrap0", 8'h05, 8'h01, 3'd0, 1'b1, 1'b0);
      tick();
      mask4 = 8'h00;
      push(1'b0, "mask_none", 8'h05, 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      mask4 = 8'h10;
      push(1'b0, "mask_wrap4", 8'h05, 8'h10, 3'd4, 1'b1, 1'b0);
      tick();
      mask4 = 8'h80;
      push(1'b0, "mask_fwd7", 8'h05, 8'h80, 3'd7, 1'b1, 1'b0);
      tick();
      mask4 = 8'h60;
      push(1'b0, "mask_start5", 8'h05, 8'h20, 3'd5, 1'b1, 1'b0);
      tick();
      mask4 = 8'hFF;

      load4 = 1'b1; en4 = 1'b1; seed4 = 4'hF;
      tick();
      load4 = 1'b0;
`ifdef LFSR_WAY_PICKER_LOCKUP_RECOVER_EN
      push_full4("lockup_pulse", 4'hF, 1'b1);
      tick();
      push_full4("lockup_recover", 4'h0, 1'b0);
`else
      push_full4("allones_a", 4'hF, 1'b0);
      tick();
      push_full4("allones_b", 4'hF, 1'b0);
      tick();
      push_full4("allones_c", 4'hF, 1'b0);
`endif
      en4 = 1'b0; load4 = 1'b1; seed4 = 4'h0;
      tick();
      load4 = 1'b0; en4 = 1'b1;
      tick();
      tick();
      tick();
      push_full4("pre_reset7", 4'h7, 1'b0);
      @(negedge clk);
      #1;
      rst4 = 1'b1;
      #1;
      push_full4("async_reset", 4'h0, 1'b0);
      -> mon_ev;
      tick();
      rst4 = 1'b0;
      push_full4("reset_held", 4'h0, 1'b0);
      tick();
      push_full4("resume1", 4'h1, 1'b0);
      tick();
      push_full4("resume3", 4'h3, 1'b0);
      en4 = 1'b0;

      en8 = 1'b1;
      steps = 0;
      seen_ones = 1'b0;
      do begin
         tick();
         steps++;
         if (st8 == 8'hFF) seen_ones = 1'b1;
      end while (st8 != 8'h00 && steps < 300);
      en8 = 1'b0;
      n_checks++;
      if (steps != 255) begin
         n_fail++;
         $display("FAIL period8: got %0d steps, want 255", steps);
      end
      n_checks++;
      if (seen_ones) begin
         n_fail++;
         $display("FAIL period8_allones: all-ones visited, want never");
      end

      tick();
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lfsr_way_picker.md
LFSR_WAY_PICKER -- requirements
Module: lfsr_way_picker

Interface
REQ-001 SHALL have parameter LFSR_WIDTH, default 8: LFSR state width; legal values 4, 5, 6, 7, 8, 12, 16, 24, 32.
REQ-002 SHALL have parameter WAYS, default 8: number of selectable ways; power of two, 2 <= WAYS <= 2**LFSR_WIDTH.
REQ-003 SHALL have parameter SEED, default all-zero, LFSR_WIDTH bits: reset and recovery state; SHALL NOT be all-ones.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port en_i, input, 1 bit: advance the LFSR by one step.
REQ-007 SHALL have port load_i, input, 1 bit: load seed_i into the state.
REQ-008 SHALL have port seed_i, input, LFSR_WIDTH bits: runtime seed value.
REQ-009 SHALL have port mask_i, input, WAYS bits: a 1 marks that way as eligible.
REQ-010 SHALL have port way_oh_o, output, WAYS bits: one-hot selected way.
REQ-011 SHALL have port way_bin_o, output, $clog2(WAYS) bits: binary index of the selected way.
REQ-012 SHALL have port way_valid_o, output, 1 bit: high when an eligible way was selected.
REQ-013 SHALL have port state_o, output, LFSR_WIDTH bits: current LFSR state.
REQ-014 SHALL have port lockup_o, output, 1 bit: pulses high when lock-up recovery fires.

Function
REQ-015 SHALL use a Fibonacci XNOR LFSR: each step shifts left, and bit 0 takes the XNOR of the tap bits (tap n means state bit n-1).
REQ-016 SHALL use these taps: 4:{4,3}; 5:{5,3}; 6:{6,5}; 7:{7,6}; 8:{8,6,5,4}; 12:{12,6,4,1}; 16:{16,15,13,4}; 24:{24,23,22,17}; 32:{32,22,2,1}.
REQ-017 SHALL give every legal width a period of 2**LFSR_WIDTH-1, with the all-ones state excluded.
REQ-018 SHALL assign next state by priority: recovery (REQ-028) first, then load_i (state = seed_i), then en_i (one step), otherwise hold.
REQ-019 SHALL give load_i priority when load_i and en_i are both high, with no step taken that cycle.
REQ-020 SHALL form the start index from state_o[$clog2(WAYS)-1:0].
REQ-021 SHALL select the first way with mask_i=1, scanning upward from the start index and wrapping from WAYS-1 to 0.
REQ-022 SHALL drive selection outputs combinationally from the current state and mask_i, with zero latency.
REQ-023 SHALL drive way_valid_o=0, way_oh_o=0 and way_bin_o=0 when mask_i is all-zero.
REQ-024 SHALL keep way_oh_o and way_bin_o consistent at all times, with exactly one bit of way_oh_o set whenever way_valid_o=1.

Reset
REQ-025 SHALL set state to SEED immediately on assertion of rst_i, independent of clk_i, including mid-sequence.
REQ-026 SHALL hold lockup_o=0 while rst_i is high and leave selection outputs reflecting state SEED.
REQ-027 SHALL resume operation on the first rising clk_i edge after rst_i deasserts.

Configuration
REQ-028 SHALL implement lock-up recovery when macro LFSR_WAY_PICKER_LOCKUP_RECOVER_EN is defined: whenever the state is all-ones, the next edge loads SEED regardless of en_i or load_i, and lockup_o is high during that cycle.
REQ-029 SHALL, when LFSR_WAY_PICKER_LOCKUP_RECOVER_EN is undefined, tie lockup_o to 0 and keep the all-ones state (entered only via load_i) while en_i=1, until load_i or reset.
REQ-030 SHALL, in simulation only, fatally stop on an illegal LFSR_WIDTH, a non-power-of-two WAYS, WAYS > 2**LFSR_WIDTH, or an all-ones SEED.

Verification
REQ-031 SHALL cover stepping: LFSR_WIDTH=4, SEED=0, en_i=1 for 16 cycles -> state_o = 0,1,3,7,E,D,B,6,C,9,2,5,A,4,8,0.
REQ-032 SHALL cover full period: LFSR_WIDTH=8, en_i=1 held -> state first returns to SEED after exactly 255 steps, and all-ones is never visited.
REQ-033 SHALL cover masked selection: WAYS=8, state low bits=5, mask_i=8'b0000_0011 -> wrap to way 0 (way_bin_o=0, way_oh_o=8'h01, way_valid_o=1); mask_i=0 -> way_valid_o=0, outputs 0.
REQ-034 SHALL cover load priority: load_i=1, en_i=1, seed_i=4'hA -> next state_o=A, not stepped; hold (en_i=0, load_i=0) -> state_o stays A.
REQ-035 SHALL cover lock-up: load seed_i=all-ones with the macro defined -> next cycle lockup_o=1, following state=SEED; without the macro -> state stays all-ones with en_i=1 and lockup_o=0.
REQ-036 SHALL cover reset mid-operation: assert rst_i asynchronously between edges at state 7 -> state_o=SEED immediately; stepping resumes from SEED after deassertion.
